// File: rtl/counter_drv_pkg.sv
// Shared types and constants for the counter stop driver.
package counter_drv_pkg;

  localparam int CW_DEF = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RSTD,
    S_START,
    S_RUN,
    S_SETTLE,
    S_RESP
  } drv_state_t;

  localparam logic [1:0] ERR_OK         = 2'd0;
  localparam logic [1:0] ERR_BAD_TARGET = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT    = 2'd2;
  localparam logic [1:0] ERR_BAD_FINAL  = 2'd3;

  // Width needed for one timer to count up to the largest of three phase lengths.
  function automatic int tmr_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/drv_cycle_timer.sv
// Free-running cycle timer with synchronous clear and count enable.
module drv_cycle_timer #(
  parameter int TW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_enable,
  output logic [TW-1:0] o_count
);

  logic [TW-1:0] r_count;

  // Clear wins over enable so a phase always starts counting from zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + TW'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/counter_stop_driver.sv
// Drives one start/stop counter FSM through a reset/start/stop run and
// reports the frozen final count.
//
// state    | meaning
// S_IDLE   | counter held in reset, waiting for a command
// S_RSTD   | counter reset held for RST_CYC cycles
// S_START  | one-cycle start pulse, counter reset released
// S_RUN    | waiting for counter==target-1, bounded by TIMEOUT
// S_SETTLE | stop pulse cycle, then final count must hold SETTLE cycles
// S_RESP   | response held until consumer accepts it
module counter_stop_driver
  import counter_drv_pkg::*;
#(
  parameter int CW      = CW_DEF,
  parameter int STOP_LO = 5,
  parameter int STOP_HI = 6,
  parameter int RST_CYC = 2,
  parameter int SETTLE  = 3,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_cmd_valid,
  output logic          o_cmd_ready,
  input  logic [CW-1:0] i_cmd_target,
  output logic          o_rsp_valid,
  input  logic          i_rsp_ready,
  output logic [CW-1:0] o_rsp_count,
  output logic [1:0]    o_rsp_err,
  output logic          o_dut_rst,
  output logic          o_start,
  output logic          o_stop,
  input  logic [CW-1:0] i_counter
);

  localparam int TMR_W = tmr_width(RST_CYC, SETTLE, TIMEOUT);

  localparam logic [CW-1:0]    TGT_LO      = CW'(STOP_LO);
  localparam logic [CW-1:0]    TGT_HI      = CW'(STOP_HI);
  localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(RST_CYC - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0] TMO_LAST    = TMR_W'(TIMEOUT - 1);

  drv_state_t     r_state;
  logic           r_cmd_ready;
  logic           r_rsp_valid;
  logic [CW-1:0]  r_rsp_count;
  logic [1:0]     r_rsp_err;
  logic           r_dut_rst;
  logic           r_start;
  logic           r_stop;
  logic [CW-1:0]  r_target;

  logic [TMR_W-1:0] w_tmr_count;
  logic             w_tmr_clear;
  logic             w_tmr_en;
  logic             w_bad_target;
  logic [CW-1:0]    w_tgt_m1;
  logic [CW-1:0]    w_tgt_p1;

  // Target arithmetic wraps in CW bits on purpose.
  assign w_tgt_m1     = r_target - CW'(1);
  assign w_tgt_p1     = r_target + CW'(1);
  assign w_bad_target = (i_cmd_target < TGT_LO) || (i_cmd_target > TGT_HI);

  // The stop cycle in S_SETTLE is not part of the hold window, so the timer restarts there.
  assign w_tmr_clear = (r_state == S_IDLE) || (r_state == S_START) ||
                       ((r_state == S_SETTLE) && r_stop);
  assign w_tmr_en    = (r_state == S_RSTD) || (r_state == S_RUN) || (r_state == S_SETTLE);

  drv_cycle_timer #(
    .TW (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_tmr_clear),
    .i_enable (w_tmr_en),
    .o_count  (w_tmr_count)
  );

  // Sequencing FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_count <= '0;
      r_rsp_err   <= ERR_OK;
      r_dut_rst   <= 1'b0;
      r_start     <= 1'b0;
      r_stop      <= 1'b0;
      r_target    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_dut_rst <= 1'b0;
          if (i_cmd_valid && r_cmd_ready) begin
            r_target    <= i_cmd_target;
            r_cmd_ready <= 1'b0;
            if (w_bad_target) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= ERR_BAD_TARGET;
              r_rsp_count <= '0;
            end else begin
              r_state <= S_RSTD;
            end
          end
        end
        S_RSTD: begin
          if (w_tmr_count == RST_LAST) begin
            r_dut_rst <= 1'b1;
            r_start   <= 1'b1;
            r_state   <= S_START;
          end
        end
        S_START: begin
          r_start <= 1'b0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          // Stop is registered, so it must be decided one count early.
          if (i_counter == w_tgt_m1) begin
            r_stop  <= 1'b1;
            r_state <= S_SETTLE;
          end else if (w_tmr_count == TMO_LAST) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= ERR_TIMEOUT;
            r_rsp_count <= i_counter;
          end
        end
        S_SETTLE: begin
          if (r_stop) begin
            r_stop <= 1'b0;
          end else if (i_counter != w_tgt_p1) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= ERR_BAD_FINAL;
            r_rsp_count <= i_counter;
          end else if (w_tmr_count == SETTLE_LAST) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= ERR_OK;
            r_rsp_count <= i_counter;
          end
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_dut_rst   <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_cmd_ready = r_cmd_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_count = r_rsp_count;
  assign o_rsp_err   = r_rsp_err;
  assign o_dut_rst   = r_dut_rst;
  assign o_start     = r_start;
  assign o_stop      = r_stop;

endmodule
